// File: rtl/mmm_pkg.sv
// Shared widths, FSM state type and pipeline tag type for the parallel-lane
// matrix-multiply engine.
package mmm_pkg;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int maxv);
    return $clog2(maxv + 1);
  endfunction

  localparam int MAXM_DEF = 8;
  localparam int MAXN_DEF = 8;
  localparam int MAXK_DEF = 8;
  localparam int A_AW_DEF = addr_w(MAXM_DEF * MAXK_DEF);
  localparam int B_AW_DEF = addr_w(MAXK_DEF * MAXN_DEF);

  localparam int LANE_W = 5;
  typedef logic [LANE_W-1:0] lane_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;

  typedef struct packed {
    logic  v;
    logic  first;
    logic  last;
    logic  fin;
    lane_t g;
  } stage_t;

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: registered product, accumulator with load-on-first, and a
// hold register that keeps a finished result while the next group accumulates.
module mac_lane #(
  parameter int INW  = 12,
  parameter int OUTW = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   prod_en,
  input  logic                   acc_en,
  input  logic                   clear,
  input  logic                   hold_en,
  input  logic signed [INW-1:0]  a,
  input  logic signed [INW-1:0]  b,
  output logic [OUTW-1:0]        hold
);

  logic signed [2*INW-1:0] prod;
  logic [OUTW-1:0]         prod_ext;
  logic [OUTW-1:0]         acc;

  always_comb prod_ext = OUTW'(prod);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod <= '0;
      acc  <= '0;
      hold <= '0;
    end else begin
      if (prod_en) prod <= a * b;
      if (acc_en)  acc  <= clear ? prod_ext : acc + prod_ext;
      if (hold_en) hold <= acc;
    end
  end

endmodule

// File: rtl/mmm_par.sv
// Matrix-multiply engine C = A*B with P parallel output-column lanes,
// credit-protected output FIFO and AXI-Stream result port.
module mmm_par
  import mmm_pkg::*;
#(
  parameter int INW  = 12,
  parameter int OUTW = 32,
  parameter int MAXM = 8,
  parameter int MAXN = 8,
  parameter int MAXK = 8,
  parameter int P    = 2,
  parameter int FD   = 2 * P
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [cnt_w(MAXM)-1:0]                cfg_m,
  input  logic [cnt_w(MAXN)-1:0]                cfg_n,
  input  logic [cnt_w(MAXK)-1:0]                cfg_k,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  cfg_err,
  output logic [addr_w(MAXM*MAXK)-1:0]          A_read_addr,
  input  logic [INW-1:0]                        A_data,
  output logic [P*addr_w(MAXK*MAXN)-1:0]        B_read_addr,
  input  logic [P*INW-1:0]                      B_data,
  output logic [OUTW-1:0]                       OUTPUT_TDATA,
  output logic                                  OUTPUT_TVALID,
  input  logic                                  OUTPUT_TREADY,
  output logic                                  OUTPUT_TLAST
);

  localparam int MW  = cnt_w(MAXM);
  localparam int NW  = cnt_w(MAXN);
  localparam int KW  = cnt_w(MAXK);
  localparam int AAW = addr_w(MAXM * MAXK);
  localparam int BAW = addr_w(MAXK * MAXN);
  localparam int CW  = cnt_w(FD);
  localparam int PW  = addr_w(FD);

  state_t state, state_nx;
  logic [MW-1:0] m_q, row;
  logic [NW-1:0] n_q, col0, g_rem;
  logic [KW-1:0] k_q, idx;
  logic [CW-1:0] credits, fifo_cnt;
  lane_t         g, cool;
  logic cfg_ok, accept, credit_ok, fire, grp_start, grp_end, row_end, job_end, pop;
  stage_t s1, s2, s3;

  always_comb begin
    cfg_ok    = (cfg_m != '0) && (int'(cfg_m) <= MAXM) &&
                (cfg_n != '0) && (int'(cfg_n) <= MAXN) &&
                (cfg_k != '0) && (int'(cfg_k) <= MAXK);
    accept    = start && (state == S_IDLE) && cfg_ok;
    g_rem     = n_q - col0;
    g         = (int'(g_rem) > P) ? lane_t'(P) : lane_t'(g_rem);
    credit_ok = int'(credits) >= int'(g);
    // A new group also waits out the previous group's push slots so that
    // very short K cannot overwrite hold registers still being drained.
    fire      = (state == S_ISSUE) && ((idx != '0) || (credit_ok && cool == '0));
    grp_start = fire && (idx == '0);
    grp_end   = fire && (int'(idx) == int'(k_q) - 1);
    row_end   = (int'(col0) + P) >= int'(n_q);
    job_end   = grp_end && row_end && (int'(row) == int'(m_q) - 1);
    pop       = OUTPUT_TVALID && OUTPUT_TREADY;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    busy        = (state != S_IDLE);
    A_read_addr = '0;
    B_read_addr = '0;
    case (state)
      S_IDLE:  if (accept) state_nx = S_ISSUE;
      S_ISSUE: begin
        if (idx == '0 && !credit_ok) state_nx = S_WAIT;
        else if (job_end)            state_nx = S_DRAIN;
      end
      S_WAIT:  if (credit_ok) state_nx = S_ISSUE;
      S_DRAIN: if (pop && OUTPUT_TLAST) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (fire) begin
      A_read_addr = AAW'(row) * AAW'(k_q) + AAW'(idx);
      for (int unsigned l = 0; l < P; l++)
        if (int'(col0) + int'(l) < int'(n_q))
          B_read_addr[l*BAW +: BAW] = BAW'(idx) * BAW'(n_q) + BAW'(col0) + BAW'(l);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q <= '0; n_q <= '0; k_q <= '0;
      row <= '0; col0 <= '0; idx <= '0;
      cool    <= '0;
      credits <= CW'(FD);
      done    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      if (accept) begin
        m_q <= cfg_m; n_q <= cfg_n; k_q <= cfg_k;
        row <= '0; col0 <= '0; idx <= '0;
      end else if (fire) begin
        if (grp_end) begin
          idx <= '0;
          if (row_end) begin
            col0 <= '0;
            row  <= job_end ? '0 : row + MW'(1);
          end else begin
            col0 <= col0 + NW'(P);
          end
        end else begin
          idx <= idx + KW'(1);
        end
      end
      if (grp_start)       cool <= g - lane_t'(1);
      else if (cool != '0) cool <= cool - lane_t'(1);
      credits <= credits - (grp_start ? CW'(g) : CW'(0)) + (pop ? CW'(1) : CW'(0));
      done    <= (state == S_DRAIN) && pop && OUTPUT_TLAST;
      cfg_err <= start && (state == S_IDLE) && !cfg_ok;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= '0; s2 <= '0; s3 <= '0;
    end else begin
      s1 <= '{v: fire, first: (idx == '0), last: grp_end, fin: job_end, g: g};
      s2 <= s1;
      s3 <= s2;
    end
  end

  logic [OUTW-1:0] hold [P];

  for (genvar l = 0; l < P; l++) begin : g_lane
    mac_lane #(.INW(INW), .OUTW(OUTW)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .prod_en (s1.v),
      .acc_en  (s2.v),
      .clear   (s2.first),
      .hold_en (s3.v && s3.last),
      .a       (A_data),
      .b       (B_data[l*INW +: INW]),
      .hold    (hold[l])
    );
  end

  logic            push_act, push_fin, push, push_last;
  lane_t           push_lane, push_g;
  logic [OUTW-1:0] push_data;

  always_comb begin
    push      = push_act;
    push_last = push_fin && (push_lane == push_g - lane_t'(1));
    push_data = '0;
    for (int unsigned l = 0; l < P; l++)
      if (lane_t'(l) == push_lane) push_data = hold[l];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      push_act <= 1'b0; push_fin <= 1'b0;
      push_lane <= '0;  push_g <= '0;
    end else if (s3.v && s3.last) begin
      push_act  <= 1'b1;
      push_lane <= '0;
      push_g    <= s3.g;
      push_fin  <= s3.fin;
    end else if (push_act) begin
      if (push_lane == push_g - lane_t'(1)) push_act <= 1'b0;
      else push_lane <= push_lane + lane_t'(1);
    end
  end

  logic [OUTW-1:0] fifo_d [FD];
  logic            fifo_l [FD];
  logic [PW-1:0]   wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_d[wr_ptr] <= push_data;
      fifo_l[wr_ptr] <= push_last;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0; rd_ptr <= '0; fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= (int'(wr_ptr) == FD - 1) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (int'(rd_ptr) == FD - 1) ? '0 : rd_ptr + PW'(1);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    OUTPUT_TVALID = (fifo_cnt != '0);
    OUTPUT_TDATA  = fifo_d[rd_ptr];
    OUTPUT_TLAST  = OUTPUT_TVALID && fifo_l[rd_ptr];
  end

endmodule
